// File: rtl/cache_refill_ctrl_if.sv
// Word-wide main-memory request/acknowledge bus between the refill controller
// (master) and the memory (slave).
interface cache_refill_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped cache refill controller: fetches four-word lines on load
// misses and forwards every store to memory (write-through, no allocate).
module cache_refill_ctrl #(
  parameter int cache_width  = 128,
  parameter int memory_width = 32,
  parameter int memory_depth = 1024,
  localparam int AW    = $clog2(memory_depth),
  localparam int WORDS = cache_width / memory_width,
  localparam int OB    = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [AW-1:0]           A,
  input  logic [memory_width-1:0] PWD,
  input  logic                    hit,
  output logic                    stall,
  output logic                    fill,
  output logic [cache_width-1:0]  MWD,
  cache_refill_ctrl_if.master     mem
);

  typedef enum logic [1:0] {IDLE, REFILL, FILL, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [OB-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           base_q, base_d;
  logic [AW-1:0]           waddr_q, waddr_d;
  logic [memory_width-1:0] wdata_q, wdata_d;
  logic [cache_width-1:0]  mwd_q, mwd_d;
  logic                    fill_q, fill_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [AW-1:0]           mem_addr_q, mem_addr_d;
  logic [memory_width-1:0] mem_wdata_q, mem_wdata_d;
  logic                    idle_stall;

  assign idle_stall = req_valid & (req_we | ~hit);

  // During reset the state register may still hold a busy state for one
  // cycle, so the processor sees the IDLE stall rule regardless.
  always_comb begin
    stall = idle_stall;
    if (!reset) begin
      case (state_q)
        REFILL:  stall = 1'b1;
        FILL:    stall = 1'b1;
        WRITE:   stall = ~mem.mem_ack;
        default: stall = idle_stall;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_we) begin
          waddr_d = A;
          wdata_d = PWD;
          state_d = WRITE;
        end else if (req_valid && !hit) begin
          base_d  = {A[AW-1:OB], {OB{1'b0}}};
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem.mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OB'(WORDS - 1)) state_d = FILL;
        end
      end
      FILL:    state_d = IDLE;
      WRITE:   if (mem.mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    fill_d      = (state_d == FILL);
    mem_req_d   = (state_d == REFILL) || (state_d == WRITE);
    mem_we_d    = (state_d == WRITE);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == REFILL) begin
      mem_addr_d = base_d + AW'(cnt_d);
    end else if (state_d == WRITE) begin
      mem_addr_d  = waddr_d;
      mem_wdata_d = wdata_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      assign mwd_d[gi*memory_width +: memory_width] =
        (state_q == REFILL && mem.mem_ack && cnt_q == OB'(gi))
          ? mem.mem_rdata
          : mwd_q[gi*memory_width +: memory_width];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      mwd_q       <= '0;
      fill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      mwd_q       <= mwd_d;
      fill_q      <= fill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign fill          = fill_q;
  assign MWD           = mwd_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_we;
  logic [9:0]   A;
  logic [31:0]  PWD;
  logic         hit;
  logic         stall;
  logic         fill;
  logic [127:0] MWD;

  cache_refill_ctrl_if #(.AW(10), .DW(32)) mem_bus ();

  cache_refill_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .A         (A),
    .PWD       (PWD),
    .hit       (hit),
    .stall     (stall),
    .fill      (fill),
    .MWD       (MWD),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  localparam int K_IDLE = 0, K_REFILL = 1, K_FILL = 2, K_WRITE = 3;

  // Model: what the controller is busy with, in transaction terms.
  int          m_kind;
  int          m_got;
  int          m_line_base;
  logic [31:0] m_line [4];
  int          m_waddr;
  logic [31:0] m_wdata;

  int n_pass = 0;
  int n_checks = 0;
  bit check_en = 1'b0;

  logic         obs_stall, obs_fill, obs_req, obs_we;
  logic [9:0]   obs_addr;
  logic [31:0]  obs_wdata;
  logic [127:0] obs_mwd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_kind = K_IDLE;
    m_got = 0;
    m_line_base = 0;
    m_waddr = 0;
    m_wdata = '0;
    for (int i = 0; i < 4; i++) m_line[i] = '0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else begin
      case (m_kind)
        K_IDLE: begin
          if (req_valid && req_we) begin
            m_kind = K_WRITE; m_waddr = int'(A); m_wdata = PWD;
          end else if (req_valid && !hit) begin
            m_kind = K_REFILL; m_line_base = (int'(A) / 4) * 4; m_got = 0;
          end
        end
        K_REFILL: begin
          if (mem_bus.mem_ack) begin
            m_line[m_got] = mem_bus.mem_rdata;
            m_got++;
            if (m_got == 4) begin m_kind = K_FILL; m_got = 0; end
          end
        end
        K_FILL:  m_kind = K_IDLE;
        default: if (mem_bus.mem_ack) m_kind = K_IDLE;
      endcase
    end
  endtask

  task automatic model_compare();
    logic e_stall;
    int   e_addr;
    if (reset || m_kind == K_IDLE) e_stall = req_valid && (req_we || !hit);
    else if (m_kind == K_WRITE)    e_stall = !mem_bus.mem_ack;
    else                           e_stall = 1'b1;
    e_addr = (m_kind == K_REFILL) ? m_line_base + m_got : (m_kind == K_WRITE) ? m_waddr : 0;
    chk("stall", 128'(stall), 128'(e_stall));
    chk("fill", 128'(fill), 128'(m_kind == K_FILL));
    chk("mem_req", 128'(mem_bus.mem_req), 128'(m_kind == K_REFILL || m_kind == K_WRITE));
    chk("mem_we", 128'(mem_bus.mem_we), 128'(m_kind == K_WRITE));
    chk("mem_addr", 128'(mem_bus.mem_addr), 128'(e_addr));
    chk("mem_wdata", 128'(mem_bus.mem_wdata), 128'((m_kind == K_WRITE) ? m_wdata : 32'h0));
    chk("MWD", MWD, {m_line[3], m_line[2], m_line[1], m_line[0]});
  endtask

  // Inputs are set by the caller at the falling edge before calling tick.
  task automatic tick();
    #1;
    obs_stall = stall; obs_fill = fill; obs_req = mem_bus.mem_req; obs_we = mem_bus.mem_we;
    obs_addr = mem_bus.mem_addr; obs_wdata = mem_bus.mem_wdata; obs_mwd = MWD;
    if (check_en) model_compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; A = '0; PWD = '0; hit = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
  endtask

  initial begin
    int stall_cnt;
    int wr_cnt;
    int w;
    logic [9:0] ack_pat;

    model_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    chk("reset_mwd", obs_mwd, 128'h0);
    chk("reset_mem_req", 128'(obs_req), 128'h0);

    // Load hit after reset.
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; hit = 1'b1; A = 10'h010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hit_stall", 128'(obs_stall), 128'h0);
      chk("hit_fill", 128'(obs_fill | obs_req), 128'h0);
    end

    // Load miss, memory acks every cycle.
    A = 10'h2B7; hit = 1'b0; mem_bus.mem_ack = 1'b1; stall_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      hit = (c >= 6);
      mem_bus.mem_rdata = (c >= 1 && c <= 4) ? 32'hA0 + 32'(c - 1) : 32'h0;
      tick();
      if (obs_stall) stall_cnt++;
      if (c >= 1 && c <= 4) chk("miss_addr", 128'(obs_addr), 128'(10'h2B4 + 10'(c - 1)));
      if (c == 5) begin
        chk("miss_fill", 128'(obs_fill), 128'h1);
        chk("miss_line", obs_mwd, 128'h000000A3_000000A2_000000A1_000000A0);
      end
    end
    chk("miss_stall_cycles", 128'(stall_cnt), 128'd6);

    // Spurious ack while idle.
    req_valid = 1'b0; mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("spur_req", 128'(obs_req | obs_fill), 128'h0);
      chk("spur_mwd", obs_mwd, 128'h000000A3_000000A2_000000A1_000000A0);
    end

    // Load miss with three wait cycles before word 2.
    req_valid = 1'b1; req_we = 1'b0; A = 10'h2B7; stall_cnt = 0; w = 0;
    ack_pat = 10'b0011000110;
    for (int c = 0; c < 10; c++) begin
      hit = (c >= 9);
      mem_bus.mem_ack = ack_pat[c];
      mem_bus.mem_rdata = 32'hB0 + 32'(w);
      tick();
      if (ack_pat[c] && c >= 1) w++;
      if (obs_stall) stall_cnt++;
      if (c >= 3 && c <= 5) chk("bp_addr_hold", 128'(obs_addr), 128'h2B6);
      if (c == 8) chk("bp_line", obs_mwd, 128'h000000B3_000000B2_000000B1_000000B0);
    end
    chk("bp_stall_cycles", 128'(stall_cnt), 128'd9);

    // Store with ack after two wait cycles.
    req_valid = 1'b1; req_we = 1'b1; A = 10'h3FF; PWD = 32'hDEADBEEF; hit = 1'b0;
    wr_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (c >= 4) req_valid = 1'b0;
      mem_bus.mem_ack = (c == 3);
      tick();
      if (obs_req && obs_we && c == 3) wr_cnt++;
      if (obs_req && obs_we && mem_bus.mem_ack && c != 3) wr_cnt++;
      if (c >= 1 && c <= 3) begin
        chk("st_addr", 128'(obs_addr), 128'h3FF);
        chk("st_wdata", 128'(obs_wdata), 128'hDEADBEEF);
      end
      if (c == 0) chk("st_stall_c0", 128'(obs_stall), 128'h1);
      if (c == 3) chk("st_stall_ack", 128'(obs_stall), 128'h0);
    end
    chk("st_writes", 128'(wr_cnt), 128'd1);

    // Reset in the middle of a refill after two words.
    req_valid = 1'b1; req_we = 1'b0; A = 10'h155; hit = 1'b0;
    for (int c = 0; c < 6; c++) begin
      reset = (c == 3);
      mem_bus.mem_ack = (c >= 1);
      mem_bus.mem_rdata = 32'hC0 + 32'(c);
      if (c >= 4) hit = 1'b1;
      tick();
      chk("rst_nofill", 128'(obs_fill), 128'h0);
      if (c >= 4) begin
        chk("rst_req", 128'(obs_req), 128'h0);
        chk("rst_stall", 128'(obs_stall), 128'h0);
        chk("rst_mwd", obs_mwd, 128'h0);
      end
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we = ($urandom_range(0, 2) == 0);
      A = 10'($urandom_range(0, 1023));
      PWD = $urandom;
      hit = $urandom_range(0, 1) == 1;
      mem_bus.mem_ack = $urandom_range(0, 1) == 1;
      mem_bus.mem_rdata = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
